// File: rtl/tl_ul_pkg.sv
// TileLink-UL shared definitions: channel opcodes, error causes and opcode helpers.
// Used by slave- and master-side blocks alike.
package tl_ul_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL_DATA    = 3'd0,
    A_PUT_PARTIAL_DATA = 3'd1,
    A_ARITHMETIC_DATA  = 3'd2,
    A_LOGICAL_DATA     = 3'd3,
    A_GET              = 3'd4,
    A_INTENT           = 3'd5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2
  } tl_d_op_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_OPCODE   = 3'd1,
    ERR_PARAM    = 3'd2,
    ERR_ADDR_LOW = 3'd3,
    ERR_RANGE    = 3'd4,
    ERR_SIZE     = 3'd5,
    ERR_ALIGN    = 3'd6,
    ERR_MASK     = 3'd7
  } tl_err_e;

  function automatic logic op_supported(input logic [2:0] a_op);
    return (a_op == A_PUT_FULL_DATA) || (a_op == A_PUT_PARTIAL_DATA) || (a_op == A_GET);
  endfunction

  // Unsupported opcodes answer with AccessAckData so the master sees a data-bearing error.
  function automatic tl_d_op_e ack_opcode(input logic [2:0] a_op);
    return ((a_op == A_PUT_FULL_DATA) || (a_op == A_PUT_PARTIAL_DATA)) ? D_ACCESS_ACK
                                                                        : D_ACCESS_ACK_DATA;
  endfunction

endpackage

// File: rtl/tl_ul_sram_slave_if.sv
// TileLink-UL A/D channel bundle between a master and the SRAM slave.
interface tl_ul_sram_slave_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int SOURCE_WIDTH = 3,
  parameter int SINK_WIDTH   = 3,
  parameter int SIZE_WIDTH   = 3
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                    a_valid;
  logic                    a_ready;
  logic [2:0]              a_opcode;
  logic [2:0]              a_param;
  logic [SIZE_WIDTH-1:0]   a_size;
  logic [ADDR_WIDTH-1:0]   a_address;
  logic [STRB_WIDTH-1:0]   a_mask;
  logic [DATA_WIDTH-1:0]   a_data;
  logic [SOURCE_WIDTH-1:0] a_source;

  logic                    d_valid;
  logic                    d_ready;
  logic [2:0]              d_opcode;
  logic [2:0]              d_param;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic [SOURCE_WIDTH-1:0] d_source;
  logic [SINK_WIDTH-1:0]   d_sink;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    d_error;

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_address, a_mask, a_data, a_source, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_address, a_mask, a_data, a_source, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error
  );
endinterface

// File: rtl/tl_ul_rsp_fifo.sv
// Response FIFO: power-of-two depth, head presented combinationally, control reset only.
module tl_ul_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q + PTR_W'(do_push);
    rptr_d  = rptr_q + PTR_W'(do_pop);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/tl_ul_sram_slave.sv
// TileLink-UL SRAM slave: decode/access at acceptance, one response stage, then an
// in-order response FIFO; A-channel credit covers both stage and FIFO occupancy.
module tl_ul_sram_slave
  import tl_ul_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    SOURCE_WIDTH = 3,
  parameter int                    SINK_WIDTH   = 3,
  parameter int                    SIZE_WIDTH   = 3,
  parameter int                    DEPTH        = 512,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    RSP_DEPTH    = 4
) (
  input logic               clk,
  input logic               rst,
  tl_ul_sram_slave_if.slave bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int LG_STRB    = $clog2(STRB_WIDTH);
  localparam int IDX_W      = $clog2(DEPTH);
  localparam int CNT_W      = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [2:0]              opcode;
    logic [SIZE_WIDTH-1:0]   size;
    logic [SOURCE_WIDTH-1:0] source;
    logic                    err;
    logic                    is_get;
  } req_t;

  typedef struct packed {
    logic [2:0]              opcode;
    logic [SIZE_WIDTH-1:0]   size;
    logic [SOURCE_WIDTH-1:0] source;
    logic                    err;
    logic [DATA_WIDTH-1:0]   data;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] offset, word_idx, align_mask;
  logic [IDX_W-1:0]      idx;
  tl_err_e               cause;
  logic                  accept, err, is_get, wr_en;

  logic                  vld_p1_q, vld_p1_d;
  req_t                  req_p1_q, req_p1_d;
  logic [DATA_WIDTH-1:0] rdata_p1_q;

  rsp_t                  push_rsp, head_rsp;
  logic                  fifo_full, fifo_empty, pop;
  logic [CNT_W-1:0]      fifo_count, credit;

  assign credit      = fifo_count + CNT_W'(vld_p1_q);
  assign bus.a_ready = !rst && !fifo_full && (credit < CNT_W'(RSP_DEPTH));
  assign accept      = bus.a_valid && bus.a_ready;

  always_comb begin
    offset     = bus.a_address - BASE_ADDR;
    word_idx   = offset >> LG_STRB;
    idx        = word_idx[IDX_W-1:0];
    align_mask = ~({ADDR_WIDTH{1'b1}} << bus.a_size);
    cause      = ERR_NONE;
    if (!op_supported(bus.a_opcode))                   cause = ERR_OPCODE;
    else if (bus.a_param != 3'd0)                      cause = ERR_PARAM;
    else if (bus.a_address < BASE_ADDR)                cause = ERR_ADDR_LOW;
    else if (word_idx >= ADDR_WIDTH'(DEPTH))           cause = ERR_RANGE;
    else if (bus.a_size > SIZE_WIDTH'(LG_STRB))        cause = ERR_SIZE;
    else if ((bus.a_address & align_mask) != '0)       cause = ERR_ALIGN;
    else if ((bus.a_opcode == A_PUT_FULL_DATA) && (bus.a_mask != '1))
                                                       cause = ERR_MASK;
    err      = (cause != ERR_NONE);
    is_get   = (bus.a_opcode == A_GET);
    wr_en    = accept && !err && !is_get;
    vld_p1_d = accept;
    req_p1_d = '{opcode: ack_opcode(bus.a_opcode), size: bus.a_size, source: bus.a_source,
                 err: err, is_get: is_get && !err};
  end

  // Stage p1: SRAM accessed at the acceptance edge; response parked here one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1_q <= 1'b0;
    else     vld_p1_q <= vld_p1_d;
  end

  always_ff @(posedge clk) begin
    if (accept) req_p1_q <= req_p1_d;
    if (accept && is_get && !err) rdata_p1_q <= mem[idx];
    if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (bus.a_mask[b]) mem[idx][8*b +: 8] <= bus.a_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    push_rsp = '{opcode: req_p1_q.opcode, size: req_p1_q.size, source: req_p1_q.source,
                 err: req_p1_q.err, data: req_p1_q.is_get ? rdata_p1_q : '0};
  end

  // Stage FIFO: credit accounting guarantees a free slot whenever vld_p1_q pushes.
  tl_ul_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vld_p1_q),
    .wdata_i (push_rsp),
    .pop_i   (pop),
    .rdata_o (head_rsp),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pop          = !fifo_empty && bus.d_ready;
  assign bus.d_valid  = !fifo_empty;
  assign bus.d_opcode = fifo_empty ? '0 : head_rsp.opcode;
  assign bus.d_param  = '0;
  assign bus.d_size   = fifo_empty ? '0 : head_rsp.size;
  assign bus.d_source = fifo_empty ? '0 : head_rsp.source;
  assign bus.d_sink   = '0;
  assign bus.d_data   = fifo_empty ? '0 : head_rsp.data;
  assign bus.d_error  = fifo_empty ? 1'b0 : head_rsp.err;
endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Directed and randomized bench for tl_ul_sram_slave against a queue/array reference model.
module tb_tl_ul_sram_slave;
  import tl_ul_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int RSPD  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tl_ul_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SOURCE_WIDTH(3),
                        .SINK_WIDTH(3), .SIZE_WIDTH(3)) bus ();

  tl_ul_sram_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SOURCE_WIDTH(3), .SINK_WIDTH(3),
                     .SIZE_WIDTH(3), .DEPTH(DEPTH), .BASE_ADDR(32'h0), .RSP_DEPTH(RSPD))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [2:0]  src;
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          n_acc;
  bit          lat_chk = 1'b0;
  bit          rnd_dr = 1'b0;
  bit          acc_seen = 1'b0;
  logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd4, 3'd2, 3'd3, 3'd5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: error and write rules evaluated directly on the accepted request.
  task automatic model_accept();
    exp_t        e;
    int unsigned a, idx, sz, op;
    logic        err;
    a   = bus.a_address;
    sz  = 32'(bus.a_size);
    op  = 32'(bus.a_opcode);
    idx = a / 4;
    err = !(op == 0 || op == 1 || op == 4) || (bus.a_param != 3'd0) || (idx >= DEPTH) ||
          ((1 << sz) > 4) || ((a % (1 << sz)) != 0) || (op == 0 && bus.a_mask != 4'hF);
    e.op   = (op <= 1) ? 3'd0 : 3'd1;
    e.size = bus.a_size;
    e.src  = bus.a_source;
    e.err  = err;
    e.data = 32'h0;
    e.cyc  = cyc;
    if (!err) begin
      if (op == 4) e.data = ref_mem[idx];
      else for (int b = 0; b < 4; b++)
        if (bus.a_mask[b]) ref_mem[idx][8*b +: 8] = bus.a_data[8*b +: 8];
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    if (rnd_dr) bus.d_ready = 1'($urandom_range(0, 1));
    #2;
    if (exp_q.size() == 0) chk("d_valid_idle", 32'(bus.d_valid), 32'd0);
    else begin
      e = exp_q[0];
      if (lat_chk) chk("d_valid_timing", 32'(bus.d_valid), 32'(cyc >= e.cyc + 2));
      if (bus.d_valid) begin
        chk("d_opcode", 32'(bus.d_opcode), 32'(e.op));
        chk("d_param",  32'(bus.d_param),  32'd0);
        chk("d_sink",   32'(bus.d_sink),   32'd0);
        chk("d_size",   32'(bus.d_size),   32'(e.size));
        chk("d_source", 32'(bus.d_source), 32'(e.src));
        chk("d_error",  32'(bus.d_error),  32'(e.err));
        if (e.op == 3'd1) chk("d_data", bus.d_data, e.data);
        if (bus.d_ready) void'(exp_q.pop_front());
      end
    end
    acc_seen = bus.a_valid && bus.a_ready;
    if (acc_seen) model_accept();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      input logic [2:0] src);
    bus.a_valid   = 1'b1;
    bus.a_opcode  = op;
    bus.a_param   = prm;
    bus.a_size    = sz;
    bus.a_address = addr;
    bus.a_mask    = mask;
    bus.a_data    = data;
    bus.a_source  = src;
    acc_seen      = 1'b0;
    for (int i = 0; i < 30 && !acc_seen; i++) tick();
    chk("a_accept", 32'(acc_seen), 32'd1);
    bus.a_valid = 1'b0;
  endtask

  task automatic put(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] src);
    send(3'd0, 3'd0, 3'd2, addr, 4'hF, data, src);
  endtask

  task automatic get(input logic [31:0] addr, input logic [2:0] src);
    send(3'd4, 3'd0, 3'd2, addr, 4'hF, 32'h0, src);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op, sz, prm;
    logic [31:0] addr;
    logic [3:0]  mask;

    rst = 1'b1;
    bus.a_valid = 1'b0; bus.a_opcode = '0; bus.a_param = '0; bus.a_size = '0;
    bus.a_address = '0; bus.a_mask = '0; bus.a_data = '0; bus.a_source = '0;
    bus.d_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_ready",  32'(bus.a_ready),  32'd0);
    chk("rst_d_valid",  32'(bus.d_valid),  32'd0);
    chk("rst_d_opcode", 32'(bus.d_opcode), 32'd0);
    chk("rst_d_source", 32'(bus.d_source), 32'd0);
    chk("rst_d_size",   32'(bus.d_size),   32'd0);
    chk("rst_d_data",   bus.d_data,        32'd0);
    chk("rst_d_error",  32'(bus.d_error),  32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_a_ready", 32'(bus.a_ready), 32'd1);

    lat_chk = 1'b1;
    for (int i = 0; i < DEPTH; i++) put(32'(4 * i), $urandom, 3'(i));
    drain();

    put(32'h8, 32'hDEADBEEF, 3'd2);
    get(32'h8, 3'd5);
    drain();
    send(3'd1, 3'd0, 3'd2, 32'h8, 4'b0101, 32'h11223344, 3'd1);
    get(32'h8, 3'd6);
    drain();

    get(32'h40, 3'd3);
    send(3'd4, 3'd0, 3'd1, 32'h3, 4'hF, 32'h0, 3'd4);
    send(3'd2, 3'd0, 3'd2, 32'h8, 4'hF, 32'h55555555, 3'd7);
    get(32'h8, 3'd0);
    send(3'd4, 3'd1, 3'd2, 32'h4, 4'hF, 32'h0, 3'd1);
    send(3'd4, 3'd0, 3'd3, 32'h0, 4'hF, 32'h0, 3'd2);
    send(3'd0, 3'd0, 3'd2, 32'hC, 4'b0111, 32'hCAFEF00D, 3'd3);
    get(32'hC, 3'd4);
    get(32'h3C, 3'd5);
    drain();

    for (int i = 0; i < 8; i++) put(32'(4 * (8 + i)), $urandom, 3'(i));
    for (int i = 0; i < 8; i++) get(32'(4 * (8 + i)), 3'(7 - i));
    drain();
    lat_chk = 1'b0;

    bus.d_ready   = 1'b0;
    n_acc         = 0;
    bus.a_valid   = 1'b1;
    bus.a_opcode  = 3'd4; bus.a_param = 3'd0; bus.a_size = 3'd2; bus.a_mask = 4'hF;
    bus.a_address = 32'h0; bus.a_source = 3'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (acc_seen) begin
        n_acc++;
        bus.a_address = 32'(4 * n_acc);
        bus.a_source  = 3'(n_acc);
      end
    end
    chk("backpressure_accepts", 32'(n_acc), 32'd4);
    chk("a_ready_when_full", 32'(bus.a_ready), 32'd0);
    bus.d_ready = 1'b1;
    for (int i = 0; i < 20 && n_acc < 6; i++) begin
      tick();
      if (acc_seen) begin
        n_acc++;
        bus.a_address = 32'(4 * n_acc);
        bus.a_source  = 3'(n_acc);
      end
    end
    bus.a_valid = 1'b0;
    chk("accepts_total", 32'(n_acc), 32'd6);
    drain();

    bus.d_ready = 1'b0;
    get(32'h0, 3'd1);
    get(32'h4, 3'd2);
    get(32'h8, 3'd3);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_d_valid", 32'(bus.d_valid), 32'd0);
    chk("midrst_a_ready", 32'(bus.a_ready), 32'd0);
    chk("midrst_d_data",  bus.d_data,       32'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rel_a_ready", 32'(bus.a_ready), 32'd1);
    chk("rel_d_valid", 32'(bus.d_valid), 32'd0);
    bus.d_ready = 1'b1;
    tick();
    get(32'h8, 3'd6);
    get(32'h3C, 3'd7);
    drain();

    rnd_dr = 1'b1;
    for (int i = 0; i < 100; i++) begin
      op   = ops[$urandom_range(0, 7)];
      addr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 'h4F))
                                         : 32'(4 * $urandom_range(0, 15));
      sz   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'd2;
      mask = (op == 3'd0 && $urandom_range(0, 5) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      prm  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd0;
      send(op, prm, sz, addr, mask, $urandom, 3'($urandom_range(0, 7)));
    end
    rnd_dr = 1'b0;
    bus.d_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/tl_ul_sram_slave.md
TL_UL_SRAM_SLAVE -- requirements
Module: tl_ul_sram_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: A-channel address width.
REQ-002 Parameter DATA_WIDTH, default 64, one of 32/64: data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-003 Parameter SOURCE_WIDTH, default 3; SINK_WIDTH, default 3; SIZE_WIDTH, default 3.
REQ-004 Parameter DEPTH, default 512: SRAM words. BASE_ADDR, default 0: byte address of word 0.
REQ-005 Parameter RSP_DEPTH, default 4, power of two >=2: maximum outstanding responses.
REQ-006 Clock and reset: reset rst, asynchronous, active-high; clock clk.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 a_valid  in  1; a_ready  out  1  A-channel handshake.
REQ-010 a_opcode  in  3; a_param  in  3; a_size  in  SIZE_WIDTH; a_address  in  ADDR_WIDTH; a_mask  in  STRB_WIDTH; a_data  in  DATA_WIDTH; a_source  in  SOURCE_WIDTH.
REQ-011 d_valid  out  1; d_ready  in  1  D-channel handshake.
REQ-012 d_opcode  out  3; d_param  out  3; d_size  out  SIZE_WIDTH; d_source  out  SOURCE_WIDTH; d_sink  out  SINK_WIDTH; d_data  out  DATA_WIDTH; d_error  out  1.

Function
REQ-013 A beat is accepted at a rising edge where a_valid && a_ready; a D beat completes at an edge where d_valid && d_ready.
REQ-014 Credit count C = in-flight beats + response-FIFO occupancy; a_ready = (C < RSP_DEPTH), combinational from registered state only, never from a_valid.
REQ-015 Word index = (a_address - BASE_ADDR) >> log2(STRB_WIDTH).
REQ-016 Request is in error if: index >= DEPTH; a_address below BASE_ADDR; a_address not aligned to 2^a_size; 2^a_size > STRB_WIDTH; a_param != 0; opcode not PutFullData(0), PutPartialData(1), or Get(4).
REQ-017 PutFullData without error: a_mask must be all ones, else error; writes a_data at the acceptance edge.
REQ-018 PutPartialData without error: writes only bytes with a_mask bit set at the acceptance edge; other bytes unchanged.
REQ-019 Get without error: SRAM read at the acceptance edge; data registered into pipeline stage.
REQ-020 Errored requests write nothing; response d_error=1, d_data=0.
REQ-021 Response fields: d_opcode = AccessAck(0) for Puts, AccessAckData(1) for Get and for unsupported opcodes; d_param=0; d_sink=0; d_size=a_size; d_source=a_source.
REQ-022 Latency: accepted at edge k, response pushed to FIFO at edge k+1, d_valid high after edge k+1 if FIFO was empty; zero-bubble throughput of one beat per cycle when d_ready held high.
REQ-023 Responses are returned strictly in acceptance order.
REQ-024 d_* held stable while d_valid && !d_ready.
REQ-025 Read-after-write: Put at edge k, Get same word at edge k+1 returns new data.
REQ-026 Simultaneous accept and D completion leave C unchanged; C never exceeds RSP_DEPTH; FIFO pointers wrap modulo RSP_DEPTH.

Reset
REQ-027 On rst: a_ready=0 while asserted, 1 on the first cycle after release; d_valid=0; all d_* fields=0; C=0; FIFO pointers=0.
REQ-028 rst mid-operation discards all in-flight and queued responses; SRAM contents are not reset.

Structure
REQ-029 Package tl_ul_pkg holds A/D opcode constants, opcode typedefs, and the error-cause encoding; shared with master-side blocks.
REQ-030 One sub-module tl_ul_rsp_fifo (parametrised width/depth, async reset, full/empty/count) holds responses; the SRAM array is inferred inline.

Verification
REQ-031 DATA_WIDTH=32, DEPTH=16: PutFull addr 0x8 data 0xDEADBEEF src 2, then Get 0x8 src 5 -> AccessAck src 2 err 0, then AccessAckData 0xDEADBEEF src 5, second d_valid two edges after its acceptance.
REQ-032 PutPartial addr 0x8 mask 0b0101 data 0x11223344 over 0xDEADBEEF, then Get -> 0xDE22BE44.
REQ-033 Get addr 0x40 (index 16) -> AccessAckData d_error=1 d_data=0; Get size 1 addr 0x3 -> d_error=1; opcode 2 -> d_error=1, SRAM unchanged.
REQ-034 d_ready=0, issue 6 Gets -> exactly 4 accepted, a_ready=0; release d_ready -> 4 responses in order, remaining 2 then accepted and returned.
REQ-035 Assert rst with 3 responses queued -> d_valid=0 next cycle, a_ready=1 after release, no stale responses, prior writes readable.
REQ-036 Back-to-back 8 Puts then 8 Gets with d_ready=1 -> one response per cycle, no bubbles, data matches.
